issue_unit: RTL
===============

ISSUE_UNIT -- requirements
Module: issue_unit

Interface
REQ-001 Parameter NREGS, default 32: scoreboard entries, one per GPR; x0 is never tracked.
REQ-002 clock_in  input  1  core clock; all state updates on rising edge.
REQ-003 reset_in  input  1  asynchronous, active-low reset.
REQ-004 dec_valid_in / dec_ready_out  in/out  1/1  decode-to-issue handshake; transfer when both high.
REQ-005 exec_unit_sel_in  input  3  one-hot unit select: 001 ALU, 010 LSU, 100 VEC.
REQ-006 exec_unit_uop_in  input  4  micro-op, passed through unchanged.
REQ-007 rs1_in, rs2_in, rd_in  input  5 each  source and destination register indices.
REQ-008 alu_valid_out, lsu_valid_out, vec_valid_out  output  1 each  per-unit issue strobes.
REQ-009 alu_ready_in, lsu_ready_in, vec_ready_in  input  1 each  per-unit accept.
REQ-010 issue_uop_out / issue_rd_out  output  4/5  shared payload bus to all units.
REQ-011 alu_done_in, lsu_done_in, vec_done_in  input  1 each  writeback-complete strobes.
REQ-012 alu_done_rd_in, lsu_done_rd_in, vec_done_rd_in  input  5 each  register completed.
REQ-013 flush_in  input  1  discard the held instruction.
REQ-014 illegal_sel_out  output  1  one-cycle pulse on a non-one-hot select.

Function
REQ-015 One-entry issue register; FSM states EMPTY, HAZARD, ISSUE.
REQ-016 dec_ready_out SHALL be high only in EMPTY; an accepted instruction is captured into the issue register.
REQ-017 On capture, the FSM SHALL go to HAZARD if rs1, rs2 or rd has its pending bit set, otherwise to ISSUE.
REQ-018 HAZARD SHALL re-evaluate every cycle and move to ISSUE in the first cycle all three pending bits are clear.
REQ-019 In ISSUE, exactly the selected unit's valid SHALL be high, with payload stable until that unit's ready is sampled high.
REQ-020 On accept, the FSM SHALL return to EMPTY and set pending[rd] unless rd is 0; issue latency is capture+1 cycle minimum.
REQ-021 Each done strobe SHALL clear pending[done_rd] at the next edge; up to three clears per cycle.
REQ-022 A set and a clear to the same rd in the same cycle SHALL leave the bit set.
REQ-023 Hazard checks SHALL use registered pending bits only (no same-cycle done bypass) unless REQ-029 applies.
REQ-024 A non-one-hot select on capture SHALL pulse illegal_sel_out, drop the instruction, and keep the FSM in EMPTY.
REQ-025 flush_in SHALL force EMPTY at the next edge from any state and drop any valid without accept; the scoreboard is untouched.
REQ-026 When flush and unit accept coincide, the accept wins: pending[rd] is set, then EMPTY.

Reset
REQ-027 Asserting reset SHALL immediately force EMPTY, clear all pending bits, drive all valids and illegal_sel_out low, and drive the payload to 0.
REQ-028 Reset assertion mid-handshake SHALL abandon the instruction; dec_ready_out SHALL be high on the first edge after release.

Configuration
REQ-029 Macro CORE101_SB_BYPASS_EN: when defined, a done strobe for register r in cycle N SHALL count as clear in the hazard check in cycle N; when undefined, the hazard clears in cycle N+1.

Structure
REQ-030 Shared package core101_pkg SHALL hold the ALU/LSU/VEC select constants, the FSM state enum and NREGS.
REQ-031 The scoreboard SHALL be sub-module issue_scoreboard: pending vector, three clear ports, one set port, three combinational lookup ports.

Verification
REQ-032 add x3 to ALU, alu_ready=1 -> alu_valid high 1 cycle after capture, pending[3]=1, dec_ready high next cycle.
REQ-033 x3 pending, next instruction rs1=3 -> HAZARD; alu_done rd=3 at cycle N -> issue at N+2 (N+1 with BYPASS_EN).
REQ-034 sel=011 -> illegal_sel_out pulses once, no valid asserted, pending unchanged.
REQ-035 LSU issue with lsu_ready low 5 cycles, then flush_in -> lsu_valid drops, EMPTY, pending[rd] remains 0.
REQ-036 vec accept for rd=7 coinciding with lsu_done rd=7 -> pending[7]=1; rd=0 issue -> pending unchanged.
REQ-037 reset_in low mid-ISSUE -> all valids 0 immediately, pending all 0, EMPTY after release.

Source files
------------

// File: rtl/core101_pkg.sv
// Shared constants and types for the core101 issue stage.
// Optional build macro CORE101_SB_BYPASS_EN is consumed by issue_scoreboard.
package core101_pkg;

    localparam int unsigned NREGS = 32;
    localparam int unsigned REG_W = 5;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam logic [2:0] SEL_ALU = 3'b001;
    localparam logic [2:0] SEL_LSU = 3'b010;
    localparam logic [2:0] SEL_VEC = 3'b100;

    typedef enum logic [1:0] {
        StEmpty,
        StHazard,
        StIssue
    } issue_state_e;

    function automatic logic sel_is_legal(input logic [2:0] sel);
        return (sel == SEL_ALU) || (sel == SEL_LSU) || (sel == SEL_VEC);
    endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register pending-write scoreboard: one set port, three clear ports, three lookups.
// With CORE101_SB_BYPASS_EN defined, same-cycle clears are visible to the lookups.
module issue_scoreboard #(
    parameter int unsigned NREGS = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  set_en_i,
    input  core101_pkg::reg_idx_t set_idx_i,
    input  logic                  clr0_en_i,
    input  core101_pkg::reg_idx_t clr0_idx_i,
    input  logic                  clr1_en_i,
    input  core101_pkg::reg_idx_t clr1_idx_i,
    input  logic                  clr2_en_i,
    input  core101_pkg::reg_idx_t clr2_idx_i,
    input  core101_pkg::reg_idx_t rs1_idx_i,
    input  core101_pkg::reg_idx_t rs2_idx_i,
    input  core101_pkg::reg_idx_t rd_idx_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic                  rd_busy_o
);

    localparam int unsigned IdxSpan = 2 ** core101_pkg::REG_W;

    logic [NREGS-1:0]   pending_q;
    logic [NREGS-1:0]   pending_d;
    logic [NREGS-1:0]   clr_vec;
    logic [NREGS-1:0]   set_vec;
    logic [IdxSpan-1:0] busy_vec;

    always_comb begin
        clr_vec   = '0;
        set_vec   = '0;
        pending_d = '0;
        busy_vec  = '0;
        // Entry 0 stays zero: x0 is never tracked.
        for (int i = 1; i < int'(NREGS); i++) begin
            clr_vec[i] = (clr0_en_i && clr0_idx_i == core101_pkg::reg_idx_t'(i)) ||
                         (clr1_en_i && clr1_idx_i == core101_pkg::reg_idx_t'(i)) ||
                         (clr2_en_i && clr2_idx_i == core101_pkg::reg_idx_t'(i));
            set_vec[i] = set_en_i && (set_idx_i == core101_pkg::reg_idx_t'(i));
            // Set dominates a coincident clear.
            pending_d[i] = set_vec[i] | (pending_q[i] & ~clr_vec[i]);
`ifdef CORE101_SB_BYPASS_EN
            busy_vec[i] = pending_q[i] & ~clr_vec[i];
`else
            busy_vec[i] = pending_q[i];
`endif
        end
    end

    assign rs1_busy_o = busy_vec[rs1_idx_i];
    assign rs2_busy_o = busy_vec[rs2_idx_i];
    assign rd_busy_o  = busy_vec[rd_idx_i];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/issue_unit.sv
// Single-entry in-order issue stage with scoreboard hazard check and per-unit handshake.
// Build option CORE101_SB_BYPASS_EN lets done strobes clear hazards in the same cycle.
module issue_unit #(
    parameter int unsigned NREGS = core101_pkg::NREGS
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       dec_valid_in,
    output logic       dec_ready_out,
    input  logic [2:0] exec_unit_sel_in,
    input  logic [3:0] exec_unit_uop_in,
    input  logic [4:0] rs1_in,
    input  logic [4:0] rs2_in,
    input  logic [4:0] rd_in,
    output logic       alu_valid_out,
    output logic       lsu_valid_out,
    output logic       vec_valid_out,
    input  logic       alu_ready_in,
    input  logic       lsu_ready_in,
    input  logic       vec_ready_in,
    output logic [3:0] issue_uop_out,
    output logic [4:0] issue_rd_out,
    input  logic       alu_done_in,
    input  logic       lsu_done_in,
    input  logic       vec_done_in,
    input  logic [4:0] alu_done_rd_in,
    input  logic [4:0] lsu_done_rd_in,
    input  logic [4:0] vec_done_rd_in,
    input  logic       flush_in,
    output logic       illegal_sel_out
);

    import core101_pkg::*;

    issue_state_e state_q, state_d;
    logic [2:0]   sel_q, sel_d;
    logic [3:0]   uop_q, uop_d;
    reg_idx_t     rd_q, rd_d;
    reg_idx_t     rs1_q, rs1_d;
    reg_idx_t     rs2_q, rs2_d;
    logic         illegal_q, illegal_d;

    reg_idx_t     lk_rs1, lk_rs2, lk_rd;
    logic         rs1_busy, rs2_busy, rd_busy;
    logic         hazard;
    logic         accept;
    logic         sb_set;

    // In EMPTY the incoming instruction is checked; otherwise the held one.
    assign lk_rs1 = (state_q == StEmpty) ? rs1_in : rs1_q;
    assign lk_rs2 = (state_q == StEmpty) ? rs2_in : rs2_q;
    assign lk_rd  = (state_q == StEmpty) ? rd_in  : rd_q;
    assign hazard = rs1_busy | rs2_busy | rd_busy;

    assign accept = (state_q == StIssue) &&
                    |(sel_q & {vec_ready_in, lsu_ready_in, alu_ready_in});

    issue_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk_i      (clock_in),
        .rst_ni     (reset_in),
        .set_en_i   (sb_set),
        .set_idx_i  (rd_q),
        .clr0_en_i  (alu_done_in),
        .clr0_idx_i (alu_done_rd_in),
        .clr1_en_i  (lsu_done_in),
        .clr1_idx_i (lsu_done_rd_in),
        .clr2_en_i  (vec_done_in),
        .clr2_idx_i (vec_done_rd_in),
        .rs1_idx_i  (lk_rs1),
        .rs2_idx_i  (lk_rs2),
        .rd_idx_i   (lk_rd),
        .rs1_busy_o (rs1_busy),
        .rs2_busy_o (rs2_busy),
        .rd_busy_o  (rd_busy)
    );

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        uop_d     = uop_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        illegal_d = 1'b0;
        sb_set    = 1'b0;
        unique case (state_q)
            StEmpty: begin
                // A coincident flush discards the incoming instruction.
                if (dec_valid_in && !flush_in) begin
                    if (sel_is_legal(exec_unit_sel_in)) begin
                        sel_d   = exec_unit_sel_in;
                        uop_d   = exec_unit_uop_in;
                        rd_d    = rd_in;
                        rs1_d   = rs1_in;
                        rs2_d   = rs2_in;
                        state_d = hazard ? StHazard : StIssue;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StHazard: begin
                if (flush_in) begin
                    state_d = StEmpty;
                end else if (!hazard) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // Accept beats flush: the destination still becomes pending.
                if (accept) begin
                    sb_set  = 1'b1;
                    state_d = StEmpty;
                end else if (flush_in) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= StEmpty;
            sel_q     <= '0;
            uop_q     <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            uop_q     <= uop_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            illegal_q <= illegal_d;
        end
    end

    assign dec_ready_out   = (state_q == StEmpty);
    assign alu_valid_out   = (state_q == StIssue) & sel_q[0];
    assign lsu_valid_out   = (state_q == StIssue) & sel_q[1];
    assign vec_valid_out   = (state_q == StIssue) & sel_q[2];
    assign issue_uop_out   = uop_q;
    assign issue_rd_out    = rd_q;
    assign illegal_sel_out = illegal_q;

endmodule
